// File: rtl/sdrc_burst_addr_cnt.sv
// SDRAM controller burst address counter: linear or page-wrapping beat
// address generator with remaining-beat count, done and overflow pulses.
module sdrc_burst_addr_cnt #(
    parameter int AW  = 13,
    parameter int LW  = 9,
    parameter int PGW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [LW-1:0] load_len,
    input  logic          load_wrap,
    input  logic          step,
    input  logic          abort,
    output logic [AW-1:0] addr,
    output logic [LW-1:0] remain,
    output logic          busy,
    output logic          last,
    output logic          done,
    output logic          ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Mask of the column bits that roll over inside a page; built through a
    // wider intermediate so PGW == AW needs no special case.
    localparam logic [AW:0]   PG_SPAN = (AW + 1)'(1) << PGW;
    localparam logic [AW-1:0] PG_MASK = AW'(PG_SPAN - (AW + 1)'(1));

    state_t        state;
    logic          wrap_mode;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] addr_next;
    logic          addr_max;
    logic          len_zero;
    logic          final_beat;

    always_comb begin
        addr_inc  = addr + AW'(1);
        addr_max  = &addr;
        len_zero  = (load_len == '0);
        final_beat = (remain == LW'(1));
        addr_next = addr_inc;
        if (wrap_mode) begin
            addr_next = (addr & ~PG_MASK) | (addr_inc & PG_MASK);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            remain    <= '0;
            wrap_mode <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            ovf  <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                remain <= '0;
            end else if (load) begin
                addr <= load_addr;
                if (len_zero) begin
                    state  <= IDLE;
                    remain <= '0;
                end else begin
                    state     <= RUN;
                    remain    <= load_len;
                    wrap_mode <= load_wrap;
                end
            end else if (step && state == RUN) begin
                addr   <= addr_next;
                remain <= remain - LW'(1);
                ovf    <= !wrap_mode && addr_max;
                if (final_beat) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign last = busy && final_beat;

endmodule

// File: tb/tb_sdrc_burst_addr_cnt.sv
// Self-checking bench for sdrc_burst_addr_cnt: directed bursts plus
// randomized traffic against an arithmetic reference model.
module tb_sdrc_burst_addr_cnt;

    localparam int AW  = 13;
    localparam int LW  = 9;
    localparam int PGW = 8;
    localparam int ASPAN = 1 << AW;
    localparam int PSPAN = 1 << PGW;

    logic          clk;
    logic          reset_n;
    logic          load;
    logic [AW-1:0] load_addr;
    logic [LW-1:0] load_len;
    logic          load_wrap;
    logic          step;
    logic          abort;
    logic [AW-1:0] addr;
    logic [LW-1:0] remain;
    logic          busy;
    logic          last;
    logic          done;
    logic          ovf;

    int checks;
    int errors;

    // reference model state
    int m_addr;
    int m_rem;
    bit m_busy;
    bit m_wrap;
    bit m_done;
    bit m_ovf;

    sdrc_burst_addr_cnt #(.AW(AW), .LW(LW), .PGW(PGW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_addr (load_addr),
        .load_len  (load_len),
        .load_wrap (load_wrap),
        .step      (step),
        .abort     (abort),
        .addr      (addr),
        .remain    (remain),
        .busy      (busy),
        .last      (last),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_addr = 0;
        m_rem  = 0;
        m_busy = 0;
        m_wrap = 0;
        m_done = 0;
        m_ovf  = 0;
    endtask

    // One clock: the model applies the same sampled inputs, then outputs
    // settle and are safe to sample 1 time unit after the edge.
    task automatic tick();
        int nxt;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            m_done = 0;
            m_ovf  = 0;
            if (abort) begin
                m_busy = 0;
                m_rem  = 0;
            end else if (load) begin
                m_addr = int'(load_addr);
                if (load_len != 0) begin
                    m_rem  = int'(load_len);
                    m_wrap = load_wrap;
                    m_busy = 1;
                end else begin
                    m_rem  = 0;
                    m_busy = 0;
                end
            end else if (step && m_busy) begin
                if (m_wrap)
                    nxt = (m_addr / PSPAN) * PSPAN + ((m_addr % PSPAN) + 1) % PSPAN;
                else
                    nxt = (m_addr + 1) % ASPAN;
                m_ovf  = !m_wrap && (m_addr == ASPAN - 1);
                m_addr = nxt;
                m_rem  = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        load      = 1'b0;
        load_addr = '0;
        load_len  = '0;
        load_wrap = 1'b0;
        step      = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({addr, remain, busy, last, done, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state addr=%h remain=%0d busy=%b last=%b done=%b ovf=%b exp all 0",
                     addr, remain, busy, last, done, ovf);
        end
        tick();
        tick();
        reset_n = 1'b1;
        step = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || addr !== '0 || remain !== '0) begin
            errors++;
            $display("FAIL idle_step_ignored busy=%b addr=%h remain=%0d exp 0/0/0",
                     busy, addr, remain);
        end
        step = 1'b0;
    endtask

    task automatic test_linear();
        logic [AW-1:0] exp_addr [4];
        exp_addr = '{13'h0FFE, 13'h0FFF, 13'h1000, 13'h1001};
        load = 1'b1; load_addr = 13'h0FFE; load_len = 9'd4; load_wrap = 1'b0;
        tick();
        load = 1'b0; step = 1'b1;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (addr !== exp_addr[b] || remain !== LW'(4 - b) || busy !== 1'b1
                || last !== (b == 3) || done !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL linear_beat%0d addr=%h remain=%0d last=%b done=%b ovf=%b exp addr=%h remain=%0d last=%b",
                         b, addr, remain, last, done, ovf, exp_addr[b], 4 - b, b == 3);
            end
            tick();
        end
        step = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || remain !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL linear_done done=%b busy=%b remain=%0d ovf=%b exp 1/0/0/0",
                     done, busy, remain, ovf);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL linear_done_pulse done=%b exp 0", done);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4];
        exp_addr = '{13'h03FE, 13'h03FF, 13'h0300, 13'h0301};
        load = 1'b1; load_addr = 13'h03FE; load_len = 9'd4; load_wrap = 1'b1;
        tick();
        load = 1'b0; step = 1'b1;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (addr !== exp_addr[b] || remain !== LW'(4 - b) || ovf !== 1'b0) begin
                errors++;
                $display("FAIL wrap_beat%0d addr=%h remain=%0d ovf=%b exp addr=%h remain=%0d ovf=0",
                         b, addr, remain, ovf, exp_addr[b], 4 - b);
            end
            tick();
        end
        step = 1'b0;
        checks++;
        if (done !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done done=%b ovf=%b exp 1/0", done, ovf);
        end
        tick();
    endtask

    task automatic test_overflow();
        load = 1'b1; load_addr = 13'h1FFF; load_len = 9'd2; load_wrap = 1'b0;
        tick();
        load = 1'b0; step = 1'b1;
        checks++;
        if (addr !== 13'h1FFF || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_beat0 addr=%h ovf=%b exp 1fff/0", addr, ovf);
        end
        tick();
        checks++;
        if (addr !== 13'h0000 || ovf !== 1'b1 || last !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_beat1 addr=%h ovf=%b last=%b done=%b exp 0000/1/1/0",
                     addr, ovf, last, done);
        end
        tick();
        step = 1'b0;
        checks++;
        if (ovf !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_done ovf=%b done=%b busy=%b exp 0/1/0", ovf, done, busy);
        end
        tick();
    endtask

    task automatic test_priority();
        load = 1'b1; load_addr = 13'h0200; load_len = 9'd5; load_wrap = 1'b0;
        tick();
        load = 1'b0; step = 1'b1;
        tick();
        tick();
        load = 1'b1; load_addr = 13'h0100; load_len = 9'd2;
        checks++;
        if (remain !== 9'd3) begin
            errors++;
            $display("FAIL prio_setup remain=%0d exp 3", remain);
        end
        tick();
        checks++;
        if (addr !== 13'h0100 || remain !== 9'd2 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL prio_load addr=%h remain=%0d busy=%b done=%b exp 0100/2/1/0",
                     addr, remain, busy, done);
        end
        load = 1'b0; abort = 1'b1;
        tick();
        checks++;
        if (addr !== 13'h0100 || remain !== '0 || busy !== 1'b0 || done !== 1'b0
            || ovf !== 1'b0) begin
            errors++;
            $display("FAIL prio_abort addr=%h remain=%0d busy=%b done=%b ovf=%b exp 0100/0/0/0/0",
                     addr, remain, busy, done, ovf);
        end
        idle_inputs();
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL prio_abort_nodone done=%b exp 0", done);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_addr = 13'h0500; load_len = 9'd8; load_wrap = 1'b0;
        tick();
        load = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({addr, remain, busy, last, done, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_mid addr=%h remain=%0d busy=%b last=%b done=%b ovf=%b exp all 0",
                     addr, remain, busy, last, done, ovf);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b done=%b exp 0/0", busy, done);
        end
        load = 1'b1; load_addr = 13'h0123; load_len = 9'd0;
        tick();
        load = 1'b0; step = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (addr !== 13'h0123 || remain !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL zero_len c%0d addr=%h remain=%0d busy=%b done=%b exp 0123/0/0/0",
                         c, addr, remain, busy, done);
            end
            tick();
        end
        step = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            abort     = ($urandom_range(0, 39) == 0);
            load      = !m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
            load_wrap = $urandom_range(0, 1) == 1;
            load_len  = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 511))
                                                    : LW'($urandom_range(0, 6));
            load_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, ASPAN - 1))
                                                    : AW'(ASPAN - 1 - $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                load_addr[PGW-1:0] = PGW'(PSPAN - 1 - $urandom_range(0, 2));
            step      = $urandom_range(0, 3) != 0;
            tick();
            checks++;
            if (addr !== AW'(m_addr) || remain !== LW'(m_rem) || busy !== m_busy
                || last !== (m_busy && m_rem == 1) || done !== m_done || ovf !== m_ovf) begin
                errors++;
                $display("FAIL random_c%0d addr=%h remain=%0d busy=%b last=%b done=%b ovf=%b exp addr=%h remain=%0d busy=%b last=%b done=%b ovf=%b",
                         n, addr, remain, busy, last, done, ovf, AW'(m_addr), m_rem,
                         m_busy, m_busy && m_rem == 1, m_done, m_ovf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        model_reset();
        idle_inputs();
        test_reset();
        test_linear();
        test_wrap();
        test_overflow();
        test_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdrc_burst_addr_cnt.md
SDRC_BURST_ADDR_CNT -- requirements
Module: sdrc_burst_addr_cnt

Interface
REQ-001 Parameter AW, default 13, SHALL set the address width in bits.
REQ-002 Parameter LW, default 9, SHALL set the burst-length width in bits.
REQ-003 Parameter PGW, default 8, SHALL set the column-page width used in wrap mode; legal range is 1 <= PGW <= AW.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 load  input  1  SHALL start a new burst.
REQ-007 load_addr  input  AW  SHALL be the start address, sampled when load=1.
REQ-008 load_len  input  LW  SHALL be the burst length in beats, sampled when load=1.
REQ-009 load_wrap  input  1  SHALL select page-wrap mode (1) or linear mode (0), sampled when load=1.
REQ-010 step  input  1  SHALL advance one beat.
REQ-011 abort  input  1  SHALL terminate the burst synchronously.
REQ-012 addr  output  AW  SHALL be the current beat address, registered.
REQ-013 remain  output  LW  SHALL be the beats remaining including the current beat, registered.
REQ-014 busy  output  1  SHALL be high while in RUN.
REQ-015 last  output  1  SHALL be high when busy=1 and remain=1; combinational from registers only.
REQ-016 done  output  1  SHALL be a one-cycle registered pulse marking burst completion.
REQ-017 ovf  output  1  SHALL be a one-cycle registered pulse marking a linear-mode wrap past all-ones.

Function
REQ-018 The FSM SHALL have two states: IDLE and RUN.
REQ-019 Control inputs SHALL be prioritised abort > load > step in every cycle.
REQ-020 On abort=1: go to IDLE, hold addr, set remain=0, no done pulse, no ovf pulse.
REQ-021 On load=1 with load_len!=0, in either state: set addr=load_addr, remain=load_len, latch wrap mode, go to RUN; a burst in progress is discarded without done.
REQ-022 On load=1 with load_len=0: set addr=load_addr, remain=0, go to IDLE, no done.
REQ-023 On step=1 in RUN without abort or load: addr takes the next-address value and remain decrements by 1.
REQ-024 Linear next address SHALL be (addr+1) mod 2^AW.
REQ-025 ovf SHALL pulse in the cycle after a linear step taken from addr = all ones.
REQ-026 Wrap-mode next address SHALL hold addr[AW-1:PGW] and set addr[PGW-1:0] = (addr[PGW-1:0]+1) mod 2^PGW.
REQ-027 ovf SHALL never assert in wrap mode.
REQ-028 When PGW=AW, wrap mode SHALL equal linear mode except that ovf is suppressed.
REQ-029 A step taken with remain=1 SHALL return the FSM to IDLE with remain=0, and done SHALL be high for exactly the next cycle.
REQ-030 step in IDLE SHALL be ignored; addr and remain hold.
REQ-031 With no step, abort or load in RUN, all state SHALL hold.
REQ-032 Latency: each step SHALL be reflected on addr/remain one clock after the sampling edge.
REQ-033 done and ovf SHALL deassert in every cycle not named in REQ-025 and REQ-029.

Reset
REQ-034 While reset_n=0, asynchronously: state=IDLE, addr=0, remain=0, busy=0, last=0, done=0, ovf=0, wrap mode=0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after reset_n rises, the block SHALL wait in IDLE for load.

Verification
REQ-036 Linear: load_addr=0x0FFE, len=4, wrap=0, step every cycle -> addr 0x0FFE, 0x0FFF, 0x1000, 0x1001; last on beat 4; done one cycle after beat 4; ovf never.
REQ-037 Wrap (PGW=8): load_addr=0x03FE, len=4, wrap=1 -> addr 0x03FE, 0x03FF, 0x0300, 0x0301; ovf never.
REQ-038 Overflow: load_addr=0x1FFF, len=2, wrap=0 -> addr 0x1FFF, 0x0000; ovf one pulse aligned with addr=0x0000; done follows beat 2.
REQ-039 Priority: in RUN with remain=3, assert load (0x0100, len 2) and step together -> addr=0x0100, remain=2, no done; next cycle assert abort and step together -> IDLE, remain=0, no done.
REQ-040 Reset mid-burst and zero length: reset_n low at beat 2 of len 8 -> all outputs 0 immediately; after release, load with len 0 -> busy stays 0, done never.
